// File: rtl/pru_fb_if.sv
// Pixel-write, scan-out read and bank-control signals of the PRU frame buffer.
interface pru_fb_if #(
  parameter int PIX_W  = 2,
  parameter int ADDR_W = 19
);
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wrt_data;
  logic              wr_ready;
  logic              re;
  logic [ADDR_W-1:0] re_addr;
  logic [PIX_W-1:0]  rd_data;
  logic              rd_valid;
  logic              rd_frame_start;
  logic              swap_req;
  logic              swap_ack;
  logic              front_sel;
  logic              clr_req;
  logic              clr_busy;
  logic              addr_err;

  modport master (
    output we, wr_addr, wrt_data, re, re_addr, rd_frame_start, swap_req, clr_req,
    input  wr_ready, rd_data, rd_valid, swap_ack, front_sel, clr_busy, addr_err
  );

  modport slave (
    input  we, wr_addr, wrt_data, re, re_addr, rd_frame_start, swap_req, clr_req,
    output wr_ready, rd_data, rd_valid, swap_ack, front_sel, clr_busy, addr_err
  );
endinterface

// File: rtl/pru_frame_buffer.sv
// Double-buffered frame store: writer fills the back bank, scan-out reads the front,
// banks swap on a frame boundary, and a clear engine wipes the back bank.
module pru_frame_buffer #(
  parameter int               PIX_W     = 2,
  parameter int               H_RES     = 640,
  parameter int               V_RES     = 480,
  parameter int               ADDR_W    = 19,
  parameter logic [PIX_W-1:0] CLR_VAL   = '0,
  parameter                   INIT_FILE = ""
) (
  input  logic   clk,
  input  logic   rst,
  pru_fb_if.slave bus
);
  localparam int DEPTH = H_RES * V_RES;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [IDX_W-1:0] clr_cnt;
  logic             swap_pend;
  logic             front_sel;
  logic             swap_ack;
  logic             wr_ready;
  logic             clr_busy;
  logic [PIX_W-1:0] rd_data;
  logic             rd_valid;
  logic             addr_err;

  logic [PIX_W-1:0] bank0 [DEPTH];
  logic [PIX_W-1:0] bank1 [DEPTH];

  logic             wr_in_range, rd_in_range, wr_fire;
  logic             mem_we, clearing;
  logic [IDX_W-1:0] widx, ridx;
  logic [PIX_W-1:0] wdat, rdat;

  always_comb begin
    wr_in_range = {1'b0, bus.wr_addr} < DEPTH_X;
    rd_in_range = {1'b0, bus.re_addr} < DEPTH_X;
    clearing    = (state == CLEAR);
    // wr_ready is low for the whole clear, so the two write sources never collide
    wr_fire     = bus.we & wr_ready;
    mem_we      = clearing | (wr_fire & wr_in_range);
    widx        = clearing ? clr_cnt : bus.wr_addr[IDX_W-1:0];
    wdat        = clearing ? CLR_VAL : bus.wrt_data;
    ridx        = bus.re_addr[IDX_W-1:0];
    rdat        = front_sel ? bank1[ridx] : bank0[ridx];
  end

  // Bank select is the pre-swap front_sel, so a write on the swap edge lands in the new front.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (front_sel) bank0[widx] <= wdat;
      else           bank1[widx] <= wdat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      swap_pend <= 1'b0;
      front_sel <= 1'b0;
      swap_ack  <= 1'b0;
      wr_ready  <= 1'b1;
      clr_busy  <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      rd_valid <= bus.re;
      if (bus.re) rd_data <= rd_in_range ? rdat : '0;
      if ((bus.re && !rd_in_range) || (wr_fire && !wr_in_range)) addr_err <= 1'b1;

      case (state)
        IDLE: begin
          // A swap consumes the pending request; a swap_req on that same edge is absorbed.
          if (swap_pend && bus.rd_frame_start) begin
            front_sel <= ~front_sel;
            swap_ack  <= 1'b1;
            swap_pend <= 1'b0;
          end else if (bus.swap_req) begin
            swap_pend <= 1'b1;
          end
          if (bus.clr_req) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            wr_ready <= 1'b0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (bus.swap_req) swap_pend <= 1'b1;
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_IDX) begin
            state    <= IDLE;
            wr_ready <= 1'b1;
            clr_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.front_sel = front_sel;
  assign bus.swap_ack  = swap_ack;
  assign bus.wr_ready  = wr_ready;
  assign bus.clr_busy  = clr_busy;
  assign bus.rd_data   = rd_data;
  assign bus.rd_valid  = rd_valid;
  assign bus.addr_err  = addr_err;
endmodule

// File: tb/tb_pru_frame_buffer.sv
// Directed bench for pru_frame_buffer on a small 8x4 frame with CLR_VAL=2.
module tb_pru_frame_buffer;
  localparam int PIX_W  = 2;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  pru_fb_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

  pru_frame_buffer #(
    .PIX_W(PIX_W), .H_RES(8), .V_RES(4), .ADDR_W(ADDR_W), .CLR_VAL(2'd2), .INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_swap();
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    bus.rd_frame_start = 1'b1;
    tick();
    bus.rd_frame_start = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    bus.re = 1'b1;
    bus.re_addr = a;
    tick();
    bus.re = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd_data"},   32'(bus.rd_data), 0);
    chk({tag, "_rd_valid"},  32'(bus.rd_valid), 0);
    chk({tag, "_wr_ready"},  32'(bus.wr_ready), 1);
    chk({tag, "_swap_ack"},  32'(bus.swap_ack), 0);
    chk({tag, "_front_sel"}, 32'(bus.front_sel), 0);
    chk({tag, "_clr_busy"},  32'(bus.clr_busy), 0);
    chk({tag, "_addr_err"},  32'(bus.addr_err), 0);
  endtask

  initial begin
    int busy_cnt;
    int acks;
    bus.we = 0; bus.wr_addr = '0; bus.wrt_data = '0;
    bus.re = 0; bus.re_addr = '0;
    bus.rd_frame_start = 0; bus.swap_req = 0; bus.clr_req = 0;

    tick(); tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();

    // Write 3 to back addr 5, swap, read it from the front
    bus.we = 1; bus.wr_addr = 6'd5; bus.wrt_data = 2'b11;
    tick();
    bus.we = 0;
    bus.swap_req = 1;
    tick();
    bus.swap_req = 0;
    chk("no_swap_without_frame", 32'(bus.front_sel), 0);
    bus.rd_frame_start = 1;
    tick();
    bus.rd_frame_start = 0;
    chk("swap1_ack", 32'(bus.swap_ack), 1);
    chk("swap1_front", 32'(bus.front_sel), 1);
    tick();
    chk("swap1_ack_once", 32'(bus.swap_ack), 0);
    rd(6'd5);
    chk("rd5_data", 32'(bus.rd_data), 3);
    chk("rd5_valid", 32'(bus.rd_valid), 1);
    tick();
    chk("rd_idle_valid", 32'(bus.rd_valid), 0);
    chk("rd_idle_hold", 32'(bus.rd_data), 3);

    // Pending swap waits 100 cycles for a frame start
    bus.swap_req = 1;
    tick();
    bus.swap_req = 0;
    acks = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.swap_ack) acks++;
    end
    chk("wait100_acks", 32'(acks), 0);
    chk("wait100_front", 32'(bus.front_sel), 1);
    bus.rd_frame_start = 1;
    tick();
    bus.rd_frame_start = 0;
    chk("swap2_ack", 32'(bus.swap_ack), 1);
    chk("swap2_front", 32'(bus.front_sel), 0);
    tick();
    chk("swap2_ack_once", 32'(bus.swap_ack), 0);

    // swap_req coincident with a swap is absorbed
    bus.swap_req = 1;
    tick();
    bus.rd_frame_start = 1;
    tick();
    bus.swap_req = 0;
    chk("absorb_swap_ack", 32'(bus.swap_ack), 1);
    chk("absorb_front", 32'(bus.front_sel), 1);
    tick();
    bus.rd_frame_start = 0;
    chk("absorb_no_second", 32'(bus.swap_ack), 0);
    chk("absorb_front_kept", 32'(bus.front_sel), 1);

    // Clear back bank (bank0) to 2; a late write during the clear is ignored
    bus.we = 1; bus.wr_addr = 6'd7; bus.wrt_data = 2'd1;
    tick();
    bus.we = 0;
    bus.clr_req = 1;
    tick();
    bus.clr_req = 0;
    chk("clr_busy_rise", 32'(bus.clr_busy), 1);
    chk("clr_wr_ready_fall", 32'(bus.wr_ready), 0);
    busy_cnt = 1;
    for (int i = 0; i < 40; i++) begin
      bus.we = (busy_cnt == 20);
      bus.wr_addr = 6'd3; bus.wrt_data = 2'd1;
      tick();
      if (!bus.clr_busy) break;
      busy_cnt++;
    end
    bus.we = 0;
    chk("clr_busy_cycles", 32'(busy_cnt), 32);
    chk("clr_wr_ready_back", 32'(bus.wr_ready), 1);
    do_swap();
    chk("clr_swap_front", 32'(bus.front_sel), 0);
    for (int a = 0; a < DEPTH; a++) begin
      rd(ADDR_W'(a));
      chk($sformatf("clr_rd%0d", a), 32'(bus.rd_data), 2);
    end

    // clr_req + swap_req together: swap held off until the first frame start after the clear
    bus.clr_req = 1; bus.swap_req = 1;
    tick();
    bus.clr_req = 0; bus.swap_req = 0;
    chk("cs_busy", 32'(bus.clr_busy), 1);
    repeat (5) tick();
    bus.rd_frame_start = 1;
    tick();
    bus.rd_frame_start = 0;
    chk("cs_midclear_ack", 32'(bus.swap_ack), 0);
    chk("cs_midclear_front", 32'(bus.front_sel), 0);
    busy_cnt = 0;
    while (bus.clr_busy && busy_cnt < 40) begin
      tick();
      busy_cnt++;
    end
    chk("cs_clear_done", 32'(bus.clr_busy), 0);
    tick(); tick();
    chk("cs_still_pending_front", 32'(bus.front_sel), 0);
    bus.rd_frame_start = 1;
    tick();
    bus.rd_frame_start = 0;
    chk("cs_swap_ack", 32'(bus.swap_ack), 1);
    chk("cs_swap_front", 32'(bus.front_sel), 1);

    // Out-of-range accesses
    chk("err_clear_before", 32'(bus.addr_err), 0);
    rd(6'd31);
    chk("rd31_data", 32'(bus.rd_data), 2);
    rd(6'd32);
    chk("oob_rd_data", 32'(bus.rd_data), 0);
    chk("oob_rd_valid", 32'(bus.rd_valid), 1);
    chk("oob_rd_err", 32'(bus.addr_err), 1);
    bus.we = 1; bus.wr_addr = 6'd32; bus.wrt_data = 2'd3;
    tick();
    bus.we = 0;
    do_swap();
    chk("oob_swap_front", 32'(bus.front_sel), 0);
    rd(6'd0);
    chk("oob_wr_dropped", 32'(bus.rd_data), 2);
    chk("err_sticky", 32'(bus.addr_err), 1);

    // Reset in the middle of a clear
    do_swap();
    chk("pre_rst_front", 32'(bus.front_sel), 1);
    bus.clr_req = 1;
    tick();
    bus.clr_req = 0;
    repeat (10) tick();
    bus.re = 1; bus.re_addr = 6'd1;
    tick();
    chk("pre_rst_busy", 32'(bus.clr_busy), 1);
    chk("pre_rst_valid", 32'(bus.rd_valid), 1);
    bus.re = 0;
    rst = 1;
    tick();
    chk_reset("midclr_rst");
    rst = 0;
    tick();
    chk("post_rst_idle", 32'(bus.clr_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
